// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register slice: the Mode
// encoding, the default register width and the ShiftCount width helper.
// Optional feature macro used elsewhere in this slice: USR_ROTATE_EN.
package usr_pkg;

  // Default register width in bits (legal range 2..64).
  localparam int USR_DEFAULT_WIDTH = 8;

  // Operation select carried on the Mode bus.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  // Width of ShiftCount: enough bits to hold 0..WIDTH-1.
  function automatic int usr_count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Bus bundle for the universal shift register. The master side drives the
// mode and data inputs; the slave side (the register) drives the register
// view, the frame counter and the frame-done pulse.
// The optional Rotate input (USR_ROTATE_EN) is a plain port on the top
// module and is not part of this bundle.
interface universal_shift_register_if
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_DEFAULT_WIDTH
);

  localparam int CW = usr_count_width(WIDTH);

  usr_mode_e        Mode;
  logic             SerialInR;
  logic             SerialInL;
  logic [WIDTH-1:0] ParallelIn;
  logic [WIDTH-1:0] ParallelOut;
  logic             ShiftOutR;
  logic             ShiftOutL;
  logic [CW-1:0]    ShiftCount;
  logic             FrameDone;

  modport master (
    output Mode,
    output SerialInR,
    output SerialInL,
    output ParallelIn,
    input  ParallelOut,
    input  ShiftOutR,
    input  ShiftOutL,
    input  ShiftCount,
    input  FrameDone
  );

  modport slave (
    input  Mode,
    input  SerialInR,
    input  SerialInL,
    input  ParallelIn,
    output ParallelOut,
    output ShiftOutR,
    output ShiftOutL,
    output ShiftCount,
    output FrameDone
  );

endinterface

// File: rtl/usr_frame_counter.sv
// Frame counter for the universal shift register. Counts shift strobes
// modulo WIDTH and raises a registered one-cycle done pulse in the cycle
// after the shift that completes a frame. A clear aborts the current frame
// without a done pulse. Hold cycles (no strobe, no clear) keep the count.
module usr_frame_counter
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_DEFAULT_WIDTH,
  localparam int CW   = usr_count_width(WIDTH)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          i_shift,
  input  logic          i_clear,
  output logic [CW-1:0] o_count,
  output logic          o_done
);

  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;
  logic          r_done;
  logic [CW-1:0] w_count_next;
  logic          w_done_next;
  logic          w_last;

  assign w_last = (r_count == LAST_COUNT);

  // Next count and done: clear wins, a shift advances or wraps, else hold.
  always_comb begin
    w_count_next = r_count;
    w_done_next  = 1'b0;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_shift) begin
      if (w_last) begin
        w_count_next = '0;
        w_done_next  = 1'b1;
      end else begin
        w_count_next = r_count + CW'(1);
      end
    end
  end

  // Count and done flops; reset discards any partial frame.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_done  <= w_done_next;
    end
  end

  assign o_count = r_count;
  assign o_done  = r_done;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left and parallel
// load, with a frame counter that pulses FrameDone every WIDTH shifts.
// All outputs come straight from flops.
// Optional feature: define USR_ROTATE_EN to add the Rotate input, which
// turns shifts into rotates (serial inputs ignored while Rotate is 1).
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH     = USR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
`ifdef USR_ROTATE_EN
  input  logic                        Rotate,
`endif
  universal_shift_register_if.slave   bus
);

  localparam int CW = usr_count_width(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_fill_msb;
  logic             w_fill_lsb;
  logic             w_shift;
  logic             w_clear;
  logic [CW-1:0]    w_count;
  logic             w_done;

  // Bits entering the register ends: serial inputs, or the opposite end
  // of the register when rotating.
`ifdef USR_ROTATE_EN
  assign w_fill_msb = Rotate ? r_q[0]       : bus.SerialInR;
  assign w_fill_lsb = Rotate ? r_q[WIDTH-1] : bus.SerialInL;
`else
  assign w_fill_msb = bus.SerialInR;
  assign w_fill_lsb = bus.SerialInL;
`endif

  assign w_shift = (bus.Mode == MODE_SHR) || (bus.Mode == MODE_SHL);
  assign w_clear = (bus.Mode == MODE_LOAD);

  // Per-bit next-state multiplexer; end bits take the fill bits.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic w_shr_src;
      logic w_shl_src;
      logic w_bit_next;

      if (gi == WIDTH - 1) begin : g_shr_msb
        assign w_shr_src = w_fill_msb;
      end else begin : g_shr_mid
        assign w_shr_src = r_q[gi+1];
      end

      if (gi == 0) begin : g_shl_lsb
        assign w_shl_src = w_fill_lsb;
      end else begin : g_shl_mid
        assign w_shl_src = r_q[gi-1];
      end

      // Select this bit's next value from the current mode.
      always_comb begin
        w_bit_next = r_q[gi];
        unique case (bus.Mode)
          MODE_HOLD: w_bit_next = r_q[gi];
          MODE_SHR:  w_bit_next = w_shr_src;
          MODE_SHL:  w_bit_next = w_shl_src;
          MODE_LOAD: w_bit_next = bus.ParallelIn[gi];
        endcase
      end

      assign w_q_next[gi] = w_bit_next;
    end
  endgenerate

  // Register contents; reset forces RESET_VAL immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_next;
    end
  end

  usr_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .o_count (w_count),
    .o_done  (w_done)
  );

  assign bus.ParallelOut = r_q;
  assign bus.ShiftOutR   = r_q[0];
  assign bus.ShiftOutL   = r_q[WIDTH-1];
  assign bus.ShiftCount  = w_count;
  assign bus.FrameDone   = w_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: a WIDTH=4 instance (non-zero
// RESET_VAL) driven from a vector table plus hand-written reset, abort and
// back-to-back sequences, and a WIDTH=8 instance for the mixed hold/shift
// frame. Rotate checks are built only when USR_ROTATE_EN is defined.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic clk;
  logic rst_n;
  logic rotate4;
  logic rotate8;

  int checks;
  int failures;

  universal_shift_register_if #(.WIDTH(4)) bus4 ();
  universal_shift_register_if #(.WIDTH(8)) bus8 ();

  universal_shift_register #(
    .WIDTH     (4),
    .RESET_VAL (4'b0101)
  ) dut4 (
    .Clk    (clk),
    .Rst_n  (rst_n),
`ifdef USR_ROTATE_EN
    .Rotate (rotate4),
`endif
    .bus    (bus4.slave)
  );

  universal_shift_register #(
    .WIDTH (8)
  ) dut8 (
    .Clk    (clk),
    .Rst_n  (rst_n),
`ifdef USR_ROTATE_EN
    .Rotate (rotate8),
`endif
    .bus    (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    usr_mode_e  mode;
    logic       sir;
    logic       sil;
    logic [3:0] pin;
    logic [3:0] exp_q;
    logic [1:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Check all observable outputs of the WIDTH=4 instance.
  task automatic check4(input string tag, input logic [3:0] q, input logic [1:0] cnt, input logic done);
    check({tag, ".q"},    64'(bus4.ParallelOut), 64'(q));
    check({tag, ".sor"},  64'(bus4.ShiftOutR),   64'(q[0]));
    check({tag, ".sol"},  64'(bus4.ShiftOutL),   64'(q[3]));
    check({tag, ".cnt"},  64'(bus4.ShiftCount),  64'(cnt));
    check({tag, ".done"}, 64'(bus4.FrameDone),   64'(done));
    $display("txn %s q=%b cnt=%0d done=%b", tag, bus4.ParallelOut, bus4.ShiftCount, bus4.FrameDone);
  endtask

  // Apply one cycle to the WIDTH=4 instance; returns 1 ns after the edge.
  task automatic step4(input usr_mode_e m, input logic sir, input logic sil, input logic [3:0] pin);
    bus4.Mode       = m;
    bus4.SerialInR  = sir;
    bus4.SerialInL  = sil;
    bus4.ParallelIn = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input usr_mode_e m, input logic sil, input logic [7:0] pin);
    bus8.Mode       = m;
    bus8.SerialInR  = 1'b0;
    bus8.SerialInL  = sil;
    bus8.ParallelIn = pin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] m8;
    int pulses;
    int first_pulse;
    int second_pulse;

    checks   = 0;
    failures = 0;
    rotate4  = 1'b0;
    rotate8  = 1'b0;

    vecs[0]  = '{MODE_LOAD, 1'b0, 1'b0, 4'b1010, 4'b1010, 2'd0, 1'b0};
    vecs[1]  = '{MODE_HOLD, 1'b1, 1'b1, 4'b1111, 4'b1010, 2'd0, 1'b0};
    vecs[2]  = '{MODE_HOLD, 1'b0, 1'b1, 4'b0000, 4'b1010, 2'd0, 1'b0};
    vecs[3]  = '{MODE_HOLD, 1'b1, 1'b0, 4'b0101, 4'b1010, 2'd0, 1'b0};
    vecs[4]  = '{MODE_LOAD, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[5]  = '{MODE_SHR,  1'b1, 1'b0, 4'b0000, 4'b1000, 2'd1, 1'b0};
    vecs[6]  = '{MODE_SHR,  1'b1, 1'b0, 4'b0000, 4'b1100, 2'd2, 1'b0};
    vecs[7]  = '{MODE_SHR,  1'b1, 1'b0, 4'b0000, 4'b1110, 2'd3, 1'b0};
    vecs[8]  = '{MODE_SHR,  1'b1, 1'b0, 4'b0000, 4'b1111, 2'd0, 1'b1};
    vecs[9]  = '{MODE_HOLD, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0, 1'b0};
    vecs[10] = '{MODE_SHL,  1'b1, 1'b0, 4'b0000, 4'b1110, 2'd1, 1'b0};
    vecs[11] = '{MODE_HOLD, 1'b1, 1'b1, 4'b0000, 4'b1110, 2'd1, 1'b0};
    vecs[12] = '{MODE_SHR,  1'b0, 1'b1, 4'b0000, 4'b0111, 2'd2, 1'b0};
    vecs[13] = '{MODE_SHL,  1'b0, 1'b1, 4'b0000, 4'b1111, 2'd3, 1'b0};
    vecs[14] = '{MODE_LOAD, 1'b0, 1'b0, 4'b0110, 4'b0110, 2'd0, 1'b0};
    vecs[15] = '{MODE_SHL,  1'b0, 1'b1, 4'b0000, 4'b1101, 2'd1, 1'b0};
    vecs[16] = '{MODE_SHR,  1'b0, 1'b0, 4'b0000, 4'b0110, 2'd2, 1'b0};
    vecs[17] = '{MODE_SHR,  1'b1, 1'b0, 4'b0000, 4'b1011, 2'd3, 1'b0};
    vecs[18] = '{MODE_SHL,  1'b0, 1'b0, 4'b0000, 4'b0110, 2'd0, 1'b1};
    vecs[19] = '{MODE_SHL,  1'b0, 1'b1, 4'b0000, 4'b1101, 2'd1, 1'b0};

    bus4.Mode = MODE_HOLD; bus4.SerialInR = 1'b0; bus4.SerialInL = 1'b0; bus4.ParallelIn = '0;
    bus8.Mode = MODE_HOLD; bus8.SerialInR = 1'b0; bus8.SerialInL = 1'b0; bus8.ParallelIn = '0;

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check4("reset", 4'b0101, 2'd0, 1'b0);
    check("reset8.q",    64'(bus8.ParallelOut), 64'd0);
    check("reset8.cnt",  64'(bus8.ShiftCount),  64'd0);
    check("reset8.done", 64'(bus8.FrameDone),   64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors on the WIDTH=4 instance.
    for (int i = 0; i < NVEC; i++) begin
      step4(vecs[i].mode, vecs[i].sir, vecs[i].sil, vecs[i].pin);
      check4($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_done);
    end

    // Reset asserted mid-frame, between edges.
    step4(MODE_LOAD, 1'b0, 1'b0, 4'b0000);
    step4(MODE_SHR, 1'b1, 1'b0, 4'b0000);
    step4(MODE_SHR, 1'b1, 1'b0, 4'b0000);
    check4("pre_rst", 4'b1100, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check4("async_rst", 4'b0101, 2'd0, 1'b0);
    bus4.Mode = MODE_HOLD;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check4("rst_rel", 4'b0101, 2'd0, 1'b0);
    pulses = 0;
    step4(MODE_SHR, 1'b0, 1'b0, 4'b0000);
    check4("post_rst1", 4'b0010, 2'd1, 1'b0);
    pulses += int'(bus4.FrameDone);
    step4(MODE_SHR, 1'b0, 1'b0, 4'b0000);
    pulses += int'(bus4.FrameDone);
    step4(MODE_SHR, 1'b0, 1'b0, 4'b0000);
    pulses += int'(bus4.FrameDone);
    step4(MODE_SHR, 1'b0, 1'b0, 4'b0000);
    check4("post_rst4", 4'b0000, 2'd0, 1'b1);
    pulses += int'(bus4.FrameDone);
    step4(MODE_HOLD, 1'b0, 1'b0, 4'b0000);
    pulses += int'(bus4.FrameDone);
    check("post_rst_pulses", 64'(pulses), 64'd1);

    // Abort by load after 3 shifts, then 8 continuous shifts.
    step4(MODE_SHL, 1'b0, 1'b1, 4'b0000);
    step4(MODE_SHL, 1'b0, 1'b1, 4'b0000);
    step4(MODE_SHL, 1'b0, 1'b1, 4'b0000);
    check4("abort_pre", 4'b0111, 2'd3, 1'b0);
    step4(MODE_LOAD, 1'b0, 1'b0, 4'b0110);
    check4("abort_load", 4'b0110, 2'd0, 1'b0);
    pulses = 0;
    first_pulse = -1;
    second_pulse = -1;
    for (int i = 1; i <= 8; i++) begin
      step4(MODE_SHR, 1'b1, 1'b0, 4'b0000);
      check($sformatf("b2b%0d.done", i), 64'(bus4.FrameDone), 64'((i % 4) == 0));
      if (bus4.FrameDone) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else second_pulse = i;
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_spacing", 64'(second_pulse - first_pulse), 64'd4);
    check4("b2b_end", 4'b1111, 2'd0, 1'b1);
    step4(MODE_HOLD, 1'b0, 1'b0, 4'b0000);

    // WIDTH=8: load 0x81, SHL 2, hold 2, SHL 6.
    step8(MODE_LOAD, 1'b0, 8'h81);
    m8 = 8'h81;
    check("w8_load.q",   64'(bus8.ParallelOut), 64'(m8));
    check("w8_load.sol", 64'(bus8.ShiftOutL),   64'd1);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3 || i == 4) begin
        step8(MODE_HOLD, 1'b1, 8'h00);
      end else begin
        step8(MODE_SHL, 1'b0, 8'h00);
        m8 = {m8[6:0], 1'b0};
      end
      check($sformatf("w8_%0d.q", i),    64'(bus8.ParallelOut), 64'(m8));
      check($sformatf("w8_%0d.sol", i),  64'(bus8.ShiftOutL),   64'(m8[7]));
      check($sformatf("w8_%0d.done", i), 64'(bus8.FrameDone),   64'(i == 10));
      pulses += int'(bus8.FrameDone);
      $display("txn w8_%0d q=%h cnt=%0d done=%b", i, bus8.ParallelOut, bus8.ShiftCount, bus8.FrameDone);
    end
    check("w8_cnt", 64'(bus8.ShiftCount), 64'd0);
    step8(MODE_HOLD, 1'b0, 8'h00);
    pulses += int'(bus8.FrameDone);
    check("w8_pulses", 64'(pulses), 64'd1);

`ifdef USR_ROTATE_EN
    // Rotate right through a full frame; serial input ignored.
    step4(MODE_LOAD, 1'b0, 1'b0, 4'b1000);
    rotate4 = 1'b1;
    step4(MODE_SHR, 1'b1, 1'b1, 4'b0000);
    check4("rot1", 4'b0100, 2'd1, 1'b0);
    step4(MODE_SHR, 1'b1, 1'b1, 4'b0000);
    check4("rot2", 4'b0010, 2'd2, 1'b0);
    step4(MODE_SHR, 1'b1, 1'b1, 4'b0000);
    check4("rot3", 4'b0001, 2'd3, 1'b0);
    step4(MODE_SHR, 1'b1, 1'b1, 4'b0000);
    check4("rot4", 4'b1000, 2'd0, 1'b1);
    step4(MODE_SHL, 1'b0, 1'b0, 4'b0000);
    check4("rotl", 4'b0001, 2'd1, 1'b0);
    rotate4 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VAL, default all-zeros, WIDTH-bit register value at reset.
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port Mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 SHALL have port SerialInR  input  1  bit entering the MSB on shift right.
REQ-007 SHALL have port SerialInL  input  1  bit entering the LSB on shift left.
REQ-008 SHALL have port ParallelIn  input  WIDTH  load data for Mode 11.
REQ-009 SHALL have port ParallelOut  output  WIDTH  current register contents.
REQ-010 SHALL have port ShiftOutR  output  1  equals ParallelOut[0].
REQ-011 SHALL have port ShiftOutL  output  1  equals ParallelOut[WIDTH-1].
REQ-012 SHALL have port ShiftCount  output  clog2(WIDTH)  shifts completed in the current frame.
REQ-013 SHALL have port FrameDone  output  1  one-cycle pulse when a frame of WIDTH shifts completes.

Function
REQ-014 Hold (00): register and ShiftCount SHALL be unchanged and FrameDone low.
REQ-015 Shift right (01): register SHALL become {SerialInR, Q[WIDTH-1:1]} on the next edge.
REQ-016 Shift left (10): register SHALL become {Q[WIDTH-2:0], SerialInL} on the next edge.
REQ-017 Parallel load (11): register SHALL become ParallelIn, ShiftCount SHALL clear to 0, FrameDone SHALL be low.
REQ-018 ParallelOut, ShiftOutR and ShiftOutL SHALL be driven directly from register flops, with no combinational path from any input.
REQ-019 Each shift cycle, in either direction, SHALL increment ShiftCount; mixed directions within one frame SHALL be counted together.
REQ-020 On the shift that takes ShiftCount from WIDTH-1, ShiftCount SHALL wrap to 0 and FrameDone SHALL be registered high for exactly the following cycle.
REQ-021 Back-to-back frames SHALL produce one FrameDone pulse every WIDTH shift cycles with no gap cycle.
REQ-022 Hold cycles mid-frame SHALL pause counting without losing the count.
REQ-023 A parallel load on the same cycle as the WIDTH-th shift is impossible by encoding; a load mid-frame SHALL abort the frame without a FrameDone pulse.

Reset
REQ-024 Rst_n low SHALL immediately force register to RESET_VAL, ShiftCount to 0 and FrameDone to 0, regardless of Clk.
REQ-025 Reset asserted mid-frame SHALL discard the partial count; the first shift after release SHALL count as shift 1.
REQ-026 Reset release SHALL take effect on the first rising Clk edge after Rst_n goes high.

Configuration
REQ-027 Macro USR_ROTATE_EN SHALL, when defined, add input port Rotate (1 bit); when Rotate is 1, shift right SHALL feed Q[0] into the MSB and shift left SHALL feed Q[WIDTH-1] into the LSB, ignoring serial inputs; counting and FrameDone SHALL be unchanged.
REQ-028 Without USR_ROTATE_EN, the Rotate port SHALL be absent and shifts SHALL always use SerialInR/SerialInL.

Structure
REQ-029 Shared package usr_pkg SHALL hold the Mode encoding typedef (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the default WIDTH constant.
REQ-030 The frame counter and FrameDone generation SHALL be a sub-module named usr_frame_counter (inputs: shift strobe, clear; outputs: count, done).

Verification
REQ-031 WIDTH=4, reset, load 1010, hold 3 cycles -> ParallelOut stays 1010, ShiftCount 0, FrameDone never high.
REQ-032 WIDTH=4, load 0000, shift right 4 cycles with SerialInR=1 -> ParallelOut 1000, 1100, 1110, 1111; FrameDone high only in the cycle after the 4th shift; ShiftCount back to 0.
REQ-033 WIDTH=8, load 0x81, shift left 2 with SerialInL=0, hold 2, shift left 6 -> FrameDone pulses once after the 8th shift; ShiftOutL sequence 1,0,... matches model.
REQ-034 WIDTH=4, shift 2 cycles, assert Rst_n low between edges -> outputs go to RESET_VAL/0 immediately; after release, 4 further shifts produce exactly one FrameDone.
REQ-035 WIDTH=4, shift 3 cycles, then load 0110 -> ShiftCount 0, no FrameDone; 8 continuous shifts afterwards -> two FrameDone pulses exactly 4 cycles apart.
REQ-036 With USR_ROTATE_EN, WIDTH=4, load 1000, Rotate=1, shift right 4 -> 0100, 0010, 0001, 1000, with one FrameDone pulse.
